// File: rtl/mtime_serializer.sv
// Captures mtime on each active timer tick and streams it LSB slice first over a
// valid/ready link, holding one pending snapshot and counting coalesced overruns.
module mtime_serializer #(
    parameter int SliceW   = 8,
    parameter int DropCntW = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                active_i,
    input  logic                tick_i,
    input  logic [63:0]         mtime_i,
    output logic                tx_valid_o,
    input  logic                tx_ready_i,
    output logic [SliceW-1:0]   tx_data_o,
    output logic                tx_first_o,
    output logic                tx_last_o,
    output logic                busy_o,
    output logic [DropCntW-1:0] drop_cnt_o
);

    localparam int NumSlices = 64 / SliceW;
    localparam int IdxW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumSlices - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state_reg, state_next;
    logic [IdxW-1:0]     idx_reg, idx_next;
    logic [63:0]         shift_reg, shift_next;
    logic [63:0]         pend_reg, pend_next;
    logic                pend_valid_reg, pend_valid_next;
    logic [DropCntW-1:0] drop_cnt_reg, drop_cnt_next;
    logic [63:0]         shifted;
    logic                capture, handshake, last_beat, drop_event, sending;

    // Slice-wise right shift: each slice takes its upper neighbour, the top one zero-fills.
    for (genvar gi = 0; gi < NumSlices; gi++) begin : g_shift
        if (gi == NumSlices - 1) begin : g_top
            assign shifted[gi*SliceW +: SliceW] = '0;
        end else begin : g_mid
            assign shifted[gi*SliceW +: SliceW] = shift_reg[(gi+1)*SliceW +: SliceW];
        end
    end

    assign sending   = (state_reg == SEND);
    assign capture   = tick_i & active_i;
    assign handshake = sending & tx_ready_i;
    assign last_beat = (idx_reg == LastIdx);

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        shift_next      = shift_reg;
        pend_next       = pend_reg;
        pend_valid_next = pend_valid_reg;
        drop_event      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (capture) begin
                    shift_next = mtime_i;
                    idx_next   = '0;
                    state_next = SEND;
                end
            end
            SEND: begin
                if (handshake && last_beat) begin
                    idx_next        = '0;
                    pend_valid_next = 1'b0;
                    if (capture) begin
                        // Fresh tick beats the older pending snapshot, which is lost.
                        shift_next = mtime_i;
                        drop_event = pend_valid_reg;
                    end else if (pend_valid_reg && active_i) begin
                        shift_next = pend_reg;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    if (handshake) begin
                        shift_next = shifted;
                        idx_next   = idx_reg + IdxW'(1);
                    end
                    if (capture) begin
                        pend_next       = mtime_i;
                        pend_valid_next = 1'b1;
                        drop_event      = pend_valid_reg;
                    end else if (!active_i) begin
                        pend_valid_next = 1'b0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        drop_cnt_next = drop_cnt_reg;
        if (drop_event && (drop_cnt_reg != {DropCntW{1'b1}})) begin
            drop_cnt_next = drop_cnt_reg + DropCntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            shift_reg      <= '0;
            pend_reg       <= '0;
            pend_valid_reg <= 1'b0;
            drop_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            shift_reg      <= shift_next;
            pend_reg       <= pend_next;
            pend_valid_reg <= pend_valid_next;
            drop_cnt_reg   <= drop_cnt_next;
        end
    end

    // All outputs come from registered state only.
    assign tx_valid_o = sending;
    assign tx_data_o  = sending ? shift_reg[SliceW-1:0] : '0;
    assign tx_first_o = sending & (idx_reg == '0);
    assign tx_last_o  = sending & last_beat;
    assign busy_o     = sending | pend_valid_reg;
    assign drop_cnt_o = drop_cnt_reg;

endmodule

// File: tb/tb_mtime_serializer.sv
// Self-checking bench for mtime_serializer (SliceW=8): directed scenarios plus
// randomized traffic compared cycle by cycle against a frame-level reference model.
module tb_mtime_serializer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        active_i = 1'b0;
    logic        tick_i = 1'b0;
    logic [63:0] mtime_i = '0;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;
    logic [7:0]  tx_data_o;
    logic        tx_first_o;
    logic        tx_last_o;
    logic        busy_o;
    logic [15:0] drop_cnt_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    mtime_serializer #(.SliceW(8), .DropCntW(16)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .active_i   (active_i),
        .tick_i     (tick_i),
        .mtime_i    (mtime_i),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready_i),
        .tx_data_o  (tx_data_o),
        .tx_first_o (tx_first_o),
        .tx_last_o  (tx_last_o),
        .busy_o     (busy_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: a frame in flight is a 64-bit value plus how many bytes went out.
    bit          m_sending;
    logic [63:0] m_frame;
    int          m_beat;
    bit          m_pend_v;
    logic [63:0] m_pend;
    int          m_drops;

    logic [27:0] dut_vec;
    assign dut_vec = {tx_valid_o, tx_first_o, tx_last_o, busy_o, tx_data_o, drop_cnt_o};

    function automatic logic [27:0] exp_vec();
        logic [7:0] d;
        d = m_sending ? 8'(m_frame >> (8 * m_beat)) : 8'h00;
        return {m_sending, m_sending && (m_beat == 0), m_sending && (m_beat == 7),
                m_sending || m_pend_v, d, 16'(m_drops)};
    endfunction

    task automatic model_reset();
        m_sending = 0; m_frame = '0; m_beat = 0; m_pend_v = 0; m_pend = '0; m_drops = 0;
    endtask

    task automatic model_drop();
        if (m_drops < 65535) m_drops++;
    endtask

    task automatic model_update();
        bit cap;
        cap = tick_i && active_i;
        if (!m_sending) begin
            if (cap) begin m_frame = mtime_i; m_beat = 0; m_sending = 1; end
        end else if (tx_ready_i && m_beat == 7) begin
            if (cap) begin
                if (m_pend_v) model_drop();
                m_frame = mtime_i; m_beat = 0; m_pend_v = 0;
            end else if (m_pend_v && active_i) begin
                m_frame = m_pend; m_beat = 0; m_pend_v = 0;
            end else begin
                m_sending = 0; m_pend_v = 0;
            end
        end else begin
            if (tx_ready_i) m_beat++;
            if (cap) begin
                if (m_pend_v) model_drop();
                m_pend = mtime_i; m_pend_v = 1;
            end else if (!active_i) begin
                m_pend_v = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        if (!rst_i) model_update();
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        tick_i = 0; active_i = 1; tx_ready_i = 0; mtime_i = '0;
        rst_i = 1;
        @(posedge clk_i); #1;
        model_reset();
        rst_i = 0;
    endtask

    task automatic test_reset();
        rst_i = 1;
        #12;
        model_reset();
        checks++;
        if (dut_vec !== 28'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", dut_vec, 28'h0);
        end
        @(posedge clk_i); #1;
        rst_i = 0;
    endtask

    task automatic test_single_frame();
        logic [7:0] exp_bytes [8];
        exp_bytes = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        do_reset();
        tx_ready_i = 1; tick_i = 1; mtime_i = 64'h0123_4567_89AB_CDEF;
        step();
        tick_i = 0; mtime_i = '0;
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (tx_valid_o !== 1'b1 || tx_data_o !== exp_bytes[b] ||
                tx_first_o !== (b == 0) || tx_last_o !== (b == 7)) begin
                failures++;
                $display("FAIL single_beat%0d got v=%b d=%h f=%b l=%b exp v=1 d=%h f=%b l=%b",
                         b, tx_valid_o, tx_data_o, tx_first_o, tx_last_o, exp_bytes[b], b == 0, b == 7);
            end
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL single_model cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            end
            step();
        end
        checks++;
        if (tx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL single_idle got v=%b busy=%b exp v=0 busy=0", tx_valid_o, busy_o);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_bytes [8];
        bit         rdy_pat [4];
        int         beats;
        bit         prev_stall;
        logic [9:0] prev_out;
        exp_bytes = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        tick_i = 1; mtime_i = 64'h0123_4567_89AB_CDEF;
        step();
        tick_i = 0;
        beats = 0; prev_stall = 0; prev_out = '0;
        for (int c = 0; c < 64 && beats < 8; c++) begin
            tx_ready_i = rdy_pat[c % 4];
            checks++;
            if (tx_valid_o !== 1'b1) begin
                failures++;
                $display("FAIL bp_valid_drop cyc=%0d got=%b exp=1", cyc, tx_valid_o);
            end
            if (prev_stall) begin
                checks++;
                if ({tx_data_o, tx_first_o, tx_last_o} !== prev_out) begin
                    failures++;
                    $display("FAIL bp_stable cyc=%0d got=%h exp=%h", cyc, {tx_data_o, tx_first_o, tx_last_o}, prev_out);
                end
            end
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL bp_model cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            end
            if (tx_ready_i) begin
                checks++;
                if (tx_data_o !== exp_bytes[beats]) begin
                    failures++;
                    $display("FAIL bp_byte%0d got=%h exp=%h", beats, tx_data_o, exp_bytes[beats]);
                end
                beats++;
            end
            prev_stall = !tx_ready_i;
            prev_out = {tx_data_o, tx_first_o, tx_last_o};
            step();
        end
        checks++;
        if (beats != 8) begin
            failures++;
            $display("FAIL bp_timeout got beats=%0d exp=8", beats);
        end
    endtask

    task automatic test_overrun();
        logic [63:0] fval;
        logic [63:0] frames [$];
        do_reset();
        tick_i = 1; mtime_i = 64'd10; step();
        mtime_i = 64'd11; step();
        mtime_i = 64'd12; step();
        tick_i = 0; mtime_i = '0;
        step(); step();
        checks++;
        if (drop_cnt_o !== 16'd1 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL overrun_drop got drop=%0d busy=%b exp drop=1 busy=1", drop_cnt_o, busy_o);
        end
        tx_ready_i = 1;
        fval = '0;
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (tx_valid_o !== 1'b1 || tx_first_o !== (c % 8 == 0)) begin
                failures++;
                $display("FAIL overrun_stream cyc=%0d got v=%b f=%b exp v=1 f=%b", cyc, tx_valid_o, tx_first_o, c % 8 == 0);
            end
            fval = fval | (64'(tx_data_o) << (8 * (c % 8)));
            if (c % 8 == 7) begin frames.push_back(fval); fval = '0; end
            step();
        end
        checks++;
        if (frames.size() != 2 || frames[0] !== 64'd10 || frames[1] !== 64'd12) begin
            failures++;
            $display("FAIL overrun_frames got n=%0d f0=%0d f1=%0d exp n=2 f0=10 f1=12",
                     frames.size(), frames[0], frames[1]);
        end
        checks++;
        if (tx_valid_o !== 1'b0 || busy_o !== 1'b0 || drop_cnt_o !== 16'd1) begin
            failures++;
            $display("FAIL overrun_end got v=%b busy=%b drop=%0d exp v=0 busy=0 drop=1", tx_valid_o, busy_o, drop_cnt_o);
        end
    endtask

    task automatic test_last_beat_collision();
        do_reset();
        tick_i = 1; mtime_i = 64'd18; step();
        mtime_i = 64'd19; step();
        tick_i = 0; tx_ready_i = 1;
        for (int b = 0; b < 7; b++) step();
        checks++;
        if (tx_last_o !== 1'b1) begin
            failures++;
            $display("FAIL coll_at_last got last=%b exp=1", tx_last_o);
        end
        tick_i = 1; mtime_i = 64'd20;
        step();
        tick_i = 0; mtime_i = '0;
        checks++;
        if (tx_first_o !== 1'b1 || tx_data_o !== 8'd20 || drop_cnt_o !== 16'd1) begin
            failures++;
            $display("FAIL coll_next got f=%b d=%0d drop=%0d exp f=1 d=20 drop=1", tx_first_o, tx_data_o, drop_cnt_o);
        end
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL coll_model cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            end
            step();
        end
        checks++;
        if (tx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL coll_pend_cleared got v=%b busy=%b exp v=0 busy=0", tx_valid_o, busy_o);
        end
    endtask

    task automatic test_active_low();
        do_reset();
        active_i = 0; tx_ready_i = 1;
        for (int c = 0; c < 6; c++) begin
            tick_i = c[0]; mtime_i = 64'(c + 100);
            step();
            checks++;
            if (tx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
                failures++;
                $display("FAIL inactive_idle cyc=%0d got v=%b busy=%b exp v=0 busy=0", cyc, tx_valid_o, busy_o);
            end
        end
        active_i = 1; tx_ready_i = 0;
        tick_i = 1; mtime_i = 64'd30; step();
        mtime_i = 64'd31; step();
        tick_i = 0; active_i = 0;
        step();
        tx_ready_i = 1;
        for (int b = 0; b < 8; b++) begin
            tick_i = b[0]; mtime_i = 64'(b + 40);
            checks++;
            if (dut_vec !== exp_vec() || tx_valid_o !== 1'b1) begin
                failures++;
                $display("FAIL inactive_frame cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            end
            step();
        end
        tick_i = 0;
        checks++;
        if (tx_valid_o !== 1'b0 || busy_o !== 1'b0 || drop_cnt_o !== 16'd0) begin
            failures++;
            $display("FAIL inactive_end got v=%b busy=%b drop=%0d exp v=0 busy=0 drop=0", tx_valid_o, busy_o, drop_cnt_o);
        end
        active_i = 1;
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        tx_ready_i = 1; tick_i = 1; mtime_i = {$urandom, $urandom};
        step();
        tick_i = 0;
        step(); step(); step();
        rst_i = 1;
        #1;
        model_reset();
        checks++;
        if (dut_vec !== 28'h0) begin
            failures++;
            $display("FAIL rst_mid_outputs got=%h exp=%h", dut_vec, 28'h0);
        end
        @(posedge clk_i); #1;
        rst_i = 0;
        step();
        checks++;
        if (tx_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_resume got v=%b exp=0", tx_valid_o);
        end
        tick_i = 1; mtime_i = 64'd5;
        step();
        tick_i = 0;
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (tx_valid_o !== 1'b1 || tx_data_o !== ((b == 0) ? 8'h05 : 8'h00) || tx_first_o !== (b == 0)) begin
                failures++;
                $display("FAIL rst_fresh_beat%0d got v=%b d=%h f=%b", b, tx_valid_o, tx_data_o, tx_first_o);
            end
            step();
        end
    endtask

    task automatic test_saturation();
        do_reset();
        tx_ready_i = 0; tick_i = 1;
        for (int c = 0; c < 65540; c++) begin
            mtime_i = 64'(c);
            step();
            if (c == 65535 || c == 65536 || c == 65539) begin
                checks++;
                if (dut_vec !== exp_vec()) begin
                    failures++;
                    $display("FAIL sat_model tick=%0d got drop=%h exp=%h", c, drop_cnt_o, 16'(m_drops));
                end
            end
        end
        tick_i = 0;
        checks++;
        if (drop_cnt_o !== 16'hFFFF) begin
            failures++;
            $display("FAIL sat_hold got=%h exp=ffff", drop_cnt_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick_i     = ($urandom_range(0, 5) == 0);
            active_i   = ($urandom_range(0, 15) != 0);
            tx_ready_i = ($urandom_range(0, 9) < 7);
            mtime_i    = {$urandom, $urandom};
            step();
            checks++;
            if (dut_vec !== exp_vec()) begin
                failures++;
                $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, dut_vec, exp_vec());
            end
        end
        tick_i = 0; active_i = 1;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_frame();
        test_backpressure();
        test_overrun();
        test_last_beat_collision();
        test_active_low();
        test_reset_mid_frame();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
